uart_tx_frame: RTL and testbench

Parametrised UART transmitter that serialises one data word per ready/valid handshake into an asynchronous frame: start bit, configurable data bits LSB-first, optional parity bit, and one or two stop bits. The baud divider and frame sequencing are built in, and back-to-back frames are sent with no idle gap. It is the next-generation drop-in for the fixed 8-bit transmitter in the TX path, and it feeds the serial line directly.

---
 rtl/uart_tx_frame.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// Frame = start bit, DATA_BITS data bits LSB-first, optional parity bit,
// STOP_BITS stop bits. Each bit is held for CLKS_PER_BIT clocks. A word
// accepted in the last stop cycle starts the next frame with no idle gap.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
// out, ready and busy are flops loaded from the next-state decode, so
// valid and data never reach the line through combinational logic.
module uart_tx_frame #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    input  logic                 parity_odd,
    output logic                 out,
    output logic                 busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Parity bit as sent on the line: even parity over the word, inverted for odd.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] word,
                                         input logic odd);
        return (^word) ^ odd;
    endfunction

    state_t                 state_r, state_s;
    logic [BAUD_W-1:0]      baud_r, baud_s;
    logic [IDX_W-1:0]       idx_r, idx_s;
    logic                   stop_r, stop_s;
    logic [DATA_BITS-1:0]   shift_r, shift_s;
    logic                   par_r, par_s;
    logic                   out_r, out_s;
    logic                   ready_r, ready_s;
    logic                   busy_r, busy_s;
    logic                   accept_s;
    logic                   bit_end_s;

    // Next-state, datapath update and next-output decode.
    always_comb begin
        state_s   = state_r;
        baud_s    = baud_r;
        idx_s     = idx_r;
        stop_s    = stop_r;
        shift_s   = shift_r;
        par_s     = par_r;
        accept_s  = valid && ready_r;
        bit_end_s = (baud_r == BAUD_LAST);

        if (state_r != IDLE) begin
            baud_s = bit_end_s ? BAUD_ZERO : (baud_r + BAUD_ONE);
        end else begin
            baud_s = BAUD_ZERO;
        end

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    shift_s = data;
                    par_s   = calc_parity(data, parity_odd);
                    idx_s   = IDX_ZERO;
                    stop_s  = 1'b0;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    idx_s   = IDX_ZERO;
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (idx_r == IDX_LAST) begin
                        idx_s  = IDX_ZERO;
                        stop_s = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    stop_s  = 1'b0;
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    if (stop_r == STOP_LAST) begin
                        stop_s = 1'b0;
                        if (accept_s) begin
                            // Zero-gap chaining into the next frame.
                            shift_s = data;
                            par_s   = calc_parity(data, parity_odd);
                            idx_s   = IDX_ZERO;
                            state_s = START;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        stop_s = stop_r + 1'b1;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = BAUD_ZERO;
                idx_s   = IDX_ZERO;
                stop_s  = 1'b0;
            end
        endcase

        case (state_s)
            START:   out_s = 1'b0;
            DATA:    out_s = shift_s[0];
            PARITY:  out_s = par_s;
            default: out_s = 1'b1;
        endcase

        busy_s  = (state_s != IDLE);
        ready_s = (state_s == IDLE) ||
                  ((state_s == STOP) && (stop_s == STOP_LAST) && (baud_s == BAUD_LAST));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
            baud_r  <= BAUD_ZERO;
            idx_r   <= IDX_ZERO;
            stop_r  <= 1'b0;
            shift_r <= {DATA_BITS{1'b0}};
            par_r   <= 1'b0;
            out_r   <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            idx_r   <= idx_s;
            stop_r  <= stop_s;
            shift_r <= shift_s;
            par_r   <= par_s;
            out_r   <= out_s;
            ready_r <= ready_s;
            busy_r  <= busy_s;
        end
    end

    assign out   = out_r;
    assign ready = ready_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame. Two instances: A (8 data bits,
// 1 stop bit) and B (5 data bits, 2 stop bits), both 4 clocks per bit.
// Expected line values come from a frame-position model (bit period index
// within the frame), independent of the design's state machine.
module tb_uart_tx_frame;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL_A = (1 + 8 + P + 1) * CPB;
    localparam int FL_B = (1 + 5 + P + 2) * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       valid_a = 1'b0;
    logic       ready_a, out_a, busy_a;
    logic [4:0] data_b = 5'h00;
    logic       valid_b = 1'b0;
    logic       ready_b, out_b, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
        .clock(clock), .reset(reset), .data(data_a), .valid(valid_a),
        .ready(ready_a), .parity_odd(parity_odd), .out(out_a), .busy(busy_a)
    );

    uart_tx_frame #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
        .clock(clock), .reset(reset), .data(data_b), .valid(valid_b),
        .ready(ready_b), .parity_odd(parity_odd), .out(out_b), .busy(busy_b)
    );

    always #5 clock = ~clock;

    // Expected line level k cycles into a frame carrying word w.
    function automatic logic exp_bit(input logic [8:0] w, input logic odd,
                                     input int db, input int k);
        int  b;
        logic par;
        b   = k / CPB;
        par = odd;
        for (int i = 0; i < db; i++) par = par ^ w[i];
        if (b == 0) return 1'b0;
        if (b <= db) return w[b-1];
        if (P == 1 && b == db + 1) return par;
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++;
        if ({out_a, busy_a, ready_a} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_a: got out/busy/ready=%b expected 101", {out_a, busy_a, ready_a});
        end
        n_tests++;
        if ({out_b, busy_b, ready_b} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_b: got out/busy/ready=%b expected 101", {out_b, busy_b, ready_b});
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_frames();
        logic [7:0] w [8];
        logic       o [8];
        w[0] = 8'hA5; o[0] = 1'b0;
        w[1] = 8'h07; o[1] = 1'b0;
        w[2] = 8'h07; o[2] = 1'b1;
        w[3] = 8'hA5; o[3] = 1'b1;
        for (int j = 4; j < 8; j++) begin
            w[j] = 8'($urandom);
            o[j] = 1'($urandom);
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clock);
            n_tests++;
            if (ready_a !== 1'b1) begin
                n_fail++;
                $display("FAIL frame_ready_idle[%0d]: got %b expected 1", j, ready_a);
            end
            data_a = w[j]; parity_odd = o[j]; valid_a = 1'b1;
            for (int k = 0; k < FL_A; k++) begin
                @(negedge clock);
                n_tests++;
                if ({out_a, busy_a, ready_a} !== {exp_bit({1'b0, w[j]}, o[j], 8, k), 1'b1, (k == FL_A - 1)}) begin
                    n_fail++;
                    $display("FAIL frame[%0d] k=%0d word=%h: got out/busy/ready=%b expected %b", j, k, w[j],
                             {out_a, busy_a, ready_a}, {exp_bit({1'b0, w[j]}, o[j], 8, k), 1'b1, (k == FL_A - 1)});
                end
                if (k == 0) begin
                    valid_a = 1'b0; data_a = 8'($urandom); parity_odd = 1'($urandom);
                end
            end
            @(negedge clock);
            n_tests++;
            if ({out_a, busy_a, ready_a} !== 3'b101) begin
                n_fail++;
                $display("FAIL frame_end[%0d]: got out/busy/ready=%b expected 101", j, {out_a, busy_a, ready_a});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [3];
        logic       o [3];
        logic       e;
        w[0] = 8'h00; w[1] = 8'hFF; w[2] = 8'($urandom);
        for (int j = 0; j < 3; j++) o[j] = 1'($urandom);
        @(negedge clock);
        data_a = w[0]; parity_odd = o[0]; valid_a = 1'b1;
        for (int k = 0; k < 3 * FL_A; k++) begin
            @(negedge clock);
            e = exp_bit({1'b0, w[k / FL_A]}, o[k / FL_A], 8, k % FL_A);
            n_tests++;
            if ({out_a, busy_a, ready_a} !== {e, 1'b1, ((k % FL_A) == FL_A - 1)}) begin
                n_fail++;
                $display("FAIL b2b k=%0d: got out/busy/ready=%b expected %b", k,
                         {out_a, busy_a, ready_a}, {e, 1'b1, ((k % FL_A) == FL_A - 1)});
            end
            if ((k % FL_A) == 0) begin
                if (k / FL_A < 2) begin
                    data_a = w[k / FL_A + 1]; parity_odd = o[k / FL_A + 1];
                end else begin
                    valid_a = 1'b0;
                end
            end
        end
        @(negedge clock);
        n_tests++;
        if ({out_a, busy_a, ready_a} !== 3'b101) begin
            n_fail++;
            $display("FAIL b2b_end: got out/busy/ready=%b expected 101", {out_a, busy_a, ready_a});
        end
    endtask

    task automatic test_stop2();
        logic [4:0] w [4];
        logic       o [4];
        w[0] = 5'h1F; o[0] = 1'b0;
        for (int j = 1; j < 4; j++) begin
            w[j] = 5'($urandom);
            o[j] = 1'($urandom);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            data_b = w[j]; parity_odd = o[j]; valid_b = 1'b1;
            for (int k = 0; k < FL_B; k++) begin
                @(negedge clock);
                n_tests++;
                if ({out_b, busy_b, ready_b} !== {exp_bit({4'b0, w[j]}, o[j], 5, k), 1'b1, (k == FL_B - 1)}) begin
                    n_fail++;
                    $display("FAIL stop2[%0d] k=%0d word=%h: got out/busy/ready=%b expected %b", j, k, w[j],
                             {out_b, busy_b, ready_b}, {exp_bit({4'b0, w[j]}, o[j], 5, k), 1'b1, (k == FL_B - 1)});
                end
                if (k == 0) begin
                    valid_b = 1'b0; data_b = 5'($urandom);
                end
            end
            @(negedge clock);
            n_tests++;
            if ({out_b, busy_b, ready_b} !== 3'b101) begin
                n_fail++;
                $display("FAIL stop2_end[%0d]: got out/busy/ready=%b expected 101", j, {out_b, busy_b, ready_b});
            end
        end
    endtask

    task automatic test_ignore();
        logic o;
        o = 1'($urandom);
        @(negedge clock);
        data_a = 8'h55; parity_odd = o; valid_a = 1'b1;
        for (int k = 0; k < FL_A; k++) begin
            @(negedge clock);
            n_tests++;
            if ({out_a, busy_a, ready_a} !== {exp_bit(9'h055, o, 8, k), 1'b1, (k == FL_A - 1)}) begin
                n_fail++;
                $display("FAIL ignore k=%0d: got out/busy/ready=%b expected %b", k,
                         {out_a, busy_a, ready_a}, {exp_bit(9'h055, o, 8, k), 1'b1, (k == FL_A - 1)});
            end
            valid_a = 1'b0;
            if (k == 10) begin
                valid_a = 1'b1; data_a = 8'h3C; parity_odd = ~o;
            end
        end
        for (int k = 0; k < 2 * FL_A; k++) begin
            @(negedge clock);
            n_tests++;
            if ({out_a, busy_a, ready_a} !== 3'b101) begin
                n_fail++;
                $display("FAIL ignore_idle k=%0d: got out/busy/ready=%b expected 101", k, {out_a, busy_a, ready_a});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        w = 8'($urandom);
        @(negedge clock);
        data_a = w; parity_odd = 1'b0; valid_a = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clock);
            valid_a = 1'b0;
            n_tests++;
            if (out_a !== exp_bit({1'b0, w}, 1'b0, 8, k)) begin
                n_fail++;
                $display("FAIL pre_reset k=%0d: got %b expected %b", k, out_a, exp_bit({1'b0, w}, 1'b0, 8, k));
            end
        end
        reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({out_a, busy_a, ready_a} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_mid: got out/busy/ready=%b expected 101", {out_a, busy_a, ready_a});
        end
        // Reset must win over an accept on the same edge.
        valid_a = 1'b1; data_a = 8'hF0;
        @(negedge clock);
        reset = 1'b1; valid_a = 1'b0;
        n_tests++;
        if ({out_a, busy_a, ready_a} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_priority: got out/busy/ready=%b expected 101", {out_a, busy_a, ready_a});
        end
        @(negedge clock);
        n_tests++;
        if ({out_a, busy_a, ready_a} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_release: got out/busy/ready=%b expected 101", {out_a, busy_a, ready_a});
        end
        data_a = 8'h81; parity_odd = 1'b1; valid_a = 1'b1;
        for (int k = 0; k < FL_A; k++) begin
            @(negedge clock);
            valid_a = 1'b0;
            n_tests++;
            if ({out_a, busy_a, ready_a} !== {exp_bit(9'h081, 1'b1, 8, k), 1'b1, (k == FL_A - 1)}) begin
                n_fail++;
                $display("FAIL post_reset k=%0d: got out/busy/ready=%b expected %b", k,
                         {out_a, busy_a, ready_a}, {exp_bit(9'h081, 1'b1, 8, k), 1'b1, (k == FL_A - 1)});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] w;
        logic       o;
        int         gap;
        for (int j = 0; j < 6; j++) begin
            w = 8'($urandom); o = 1'($urandom); gap = int'($urandom_range(3, 0));
            for (int g = 0; g <= gap; g++) begin
                @(negedge clock);
                n_tests++;
                if ({out_a, busy_a, ready_a} !== 3'b101) begin
                    n_fail++;
                    $display("FAIL random_gap[%0d]: got out/busy/ready=%b expected 101", j, {out_a, busy_a, ready_a});
                end
            end
            data_a = w; parity_odd = o; valid_a = 1'b1;
            for (int k = 0; k < FL_A; k++) begin
                @(negedge clock);
                valid_a = 1'b0;
                n_tests++;
                if ({out_a, busy_a, ready_a} !== {exp_bit({1'b0, w}, o, 8, k), 1'b1, (k == FL_A - 1)}) begin
                    n_fail++;
                    $display("FAIL random[%0d] k=%0d word=%h: got out/busy/ready=%b expected %b", j, k, w,
                             {out_a, busy_a, ready_a}, {exp_bit({1'b0, w}, o, 8, k), 1'b1, (k == FL_A - 1)});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_stop2();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
